// File: rtl/clkgate_seq_pkg.sv
// Shared types and constants for the gated-clock controller.
// Holds the FSM state encoding and the settle/drain counter width.
// Imported by the interface-facing top and the down-counter.
package clkgate_seq_pkg;

  // Width of the shared settle/drain down-counter.
  localparam int CW = 8;

  // Controller states; encoding is fixed so it can be probed externally.
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/clkgate_seq_if.sv
// Request/acknowledge bundle between a clock consumer and the gate controller.
// Pure wiring, no latency.
// No backpressure: req/idle_i are levels, ce/ack/busy/on_cnt are status.
interface clkgate_seq_if #(
  parameter int CNTW = 8
) ();
  logic            req;
  logic            idle_i;
  logic            ce;
  logic            ack;
  logic            busy;
  logic [CNTW-1:0] on_cnt;

  // Controller side: drives the enable and status, samples the request.
  modport master (
    input  req,
    input  idle_i,
    output ce,
    output ack,
    output busy,
    output on_cnt
  );

  // Consumer side: raises the request and reports idleness.
  modport slave (
    output req,
    output idle_i,
    input  ce,
    input  ack,
    input  busy,
    input  on_cnt
  );
endinterface

// File: rtl/clkgate_seq_dlcnt.sv
// Loadable down-counter used for both the settle and the drain intervals.
// Load/decrement take effect on the next edge; zero is a decode of the count.
// No backpressure: decrement at zero is ignored (the count holds at 0).
module dlcnt
  import clkgate_seq_pkg::*;
(
  input  logic          clki,
  input  logic          rst,
  input  logic          ld,
  input  logic [CW-1:0] ldv,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clki) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ldv;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clkgate_seq.sv
// Turns a level clock request into a glitch-safe BUFGCE enable with settle and drain.
// ce rises one edge after req is seen; ack follows SETTLE edges later; all outputs registered.
// No backpressure: gating off waits (unbounded) for idle_i once the drain interval expires.
module clkgate_seq
  import clkgate_seq_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int DRAIN  = 4,
  parameter int CNTW   = 8
) (
  input  logic           clki,
  input  logic           rst,
  clkgate_seq_if.master  bus
);

  // The counter is loaded with N-1 so that the zero test lands exactly N edges later.
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN - 1);

  state_t          state;
  state_t          state_nxt;
  logic            cnt_ld;
  logic [CW-1:0]   cnt_ldv;
  logic            cnt_dec;
  logic            cnt_zero;
  logic            on_inc;
  logic            ce_r;
  logic            ack_r;
  logic            busy_r;
  logic [CNTW-1:0] on_cnt_r;

  dlcnt u_dlcnt (
    .clki (clki),
    .rst  (rst),
    .ld   (cnt_ld),
    .ldv  (cnt_ldv),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // State register; reset forces OFF regardless of any pending transition.
  always_ff @(posedge clki) begin
    if (rst) begin
      state <= ST_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter control; a dropped request always wins over settle completion.
  always_comb begin
    state_nxt = state;
    cnt_ld    = 1'b0;
    cnt_ldv   = '0;
    cnt_dec   = 1'b0;
    on_inc    = 1'b0;
    case (state)
      ST_OFF: begin
        if (bus.req) begin
          state_nxt = ST_SETTLE;
          cnt_ld    = 1'b1;
          cnt_ldv   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (!bus.req) begin
          state_nxt = ST_DRAIN;
          cnt_ld    = 1'b1;
          cnt_ldv   = DRAIN_LD;
        end else if (cnt_zero) begin
          state_nxt = ST_ON;
          on_inc    = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ON: begin
        if (!bus.req) begin
          state_nxt = ST_DRAIN;
          cnt_ld    = 1'b1;
          cnt_ldv   = DRAIN_LD;
        end
      end
      ST_DRAIN: begin
        // ce never dropped here, so a returning request skips the settle interval.
        if (bus.req) begin
          state_nxt = ST_ON;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (bus.idle_i) begin
          state_nxt = ST_OFF;
        end
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
  end

  // Outputs are registered decodes of the next state so they move on the same edge as the state.
  always_ff @(posedge clki) begin
    if (rst) begin
      ce_r     <= 1'b0;
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
      on_cnt_r <= '0;
    end else begin
      ce_r   <= (state_nxt != ST_OFF);
      ack_r  <= (state_nxt == ST_ON);
      busy_r <= (state_nxt == ST_SETTLE) || (state_nxt == ST_DRAIN);
      if (on_inc && (on_cnt_r != '1)) begin
        on_cnt_r <= on_cnt_r + CNTW'(1);
      end
    end
  end

  assign bus.ce     = ce_r;
  assign bus.ack    = ack_r;
  assign bus.busy   = busy_r;
  assign bus.on_cnt = on_cnt_r;

endmodule

// File: tb/tb_clkgate_seq.sv
// Directed bench for clkgate_seq with a timestamp-based reference model.
// Inputs change 1 ns after each rising edge; outputs are compared 1 ns after each rising edge.
// Scenario edges are numbered from the first reset edge (edge 0) of each scenario.
module tb_clkgate_seq;

  localparam int SETTLE = 4;
  localparam int DRAIN  = 4;
  localparam int CNTW   = 8;
  localparam int ON_MAX = (1 << CNTW) - 1;

  logic clki = 1'b0;
  logic rst  = 1'b1;

  clkgate_seq_if #(.CNTW(CNTW)) bus ();

  clkgate_seq #(
    .SETTLE (SETTLE),
    .DRAIN  (DRAIN),
    .CNTW   (CNTW)
  ) dut (
    .clki (clki),
    .rst  (rst),
    .bus  (bus)
  );

  always #10 clki = ~clki;

  int errors = 0;
  int checks = 0;
  int ed     = -1;

  // Reference model: tracks when ce rose and when the stop was accepted, and derives
  // ack/ce from elapsed edge counts rather than from a counter.
  int gedge   = 0;
  int t_rise  = 0;
  int t_stop  = 0;
  bit m_ce    = 1'b0;
  bit m_ack   = 1'b0;
  bit m_drain = 1'b0;
  int m_on    = 0;

  always @(posedge clki) begin
    gedge++;
    if (rst) begin
      m_ce    = 1'b0;
      m_ack   = 1'b0;
      m_drain = 1'b0;
      m_on    = 0;
    end else if (!m_ce) begin
      if (bus.req) begin
        m_ce   = 1'b1;
        t_rise = gedge;
      end
    end else if (m_drain) begin
      if (bus.req) begin
        m_drain = 1'b0;
        m_ack   = 1'b1;
      end else if ((gedge - t_stop >= DRAIN) && bus.idle_i) begin
        m_drain = 1'b0;
        m_ce    = 1'b0;
      end
    end else if (m_ack) begin
      if (!bus.req) begin
        m_ack   = 1'b0;
        m_drain = 1'b1;
        t_stop  = gedge;
      end
    end else begin
      if (!bus.req) begin
        m_drain = 1'b1;
        t_stop  = gedge;
      end else if (gedge - t_rise == SETTLE) begin
        m_ack = 1'b1;
        if (m_on < ON_MAX) m_on++;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clki) begin
    #1;
    chk("model ce",     int'(bus.ce),     int'(m_ce));
    chk("model ack",    int'(bus.ack),    int'(m_ack));
    chk("model busy",   int'(bus.busy),   int'(m_ce && !m_ack));
    chk("model on_cnt", int'(bus.on_cnt), m_on);
  end

  task automatic step(input logic r, input logic i, input logic rs);
    bus.req    = r;
    bus.idle_i = i;
    rst        = rs;
    @(posedge clki);
    #1;
    ed++;
  endtask

  task automatic hold(input int upto, input logic r, input logic i);
    while (ed < upto) step(r, i, 1'b0);
  endtask

  task automatic do_reset();
    ed = -1;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    bus.req    = 1'b0;
    bus.idle_i = 1'b1;

    // 1: power-up and settle timing
    do_reset();
    chk("rst ce", int'(bus.ce), 0);
    chk("rst ack", int'(bus.ack), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst on_cnt", int'(bus.on_cnt), 0);
    hold(2, 1'b1, 1'b1);
    chk("s1 e2 ce", int'(bus.ce), 1);
    chk("s1 e2 ack", int'(bus.ack), 0);
    chk("s1 e2 busy", int'(bus.busy), 1);
    hold(5, 1'b1, 1'b1);
    chk("s1 e5 ack", int'(bus.ack), 0);
    chk("s1 e5 busy", int'(bus.busy), 1);
    hold(6, 1'b1, 1'b1);
    chk("s1 e6 ack", int'(bus.ack), 1);
    chk("s1 e6 busy", int'(bus.busy), 0);
    chk("s1 e6 on_cnt", int'(bus.on_cnt), 1);

    // 2: stop with downstream idle
    hold(9, 1'b1, 1'b1);
    hold(10, 1'b0, 1'b1);
    chk("s2 e10 ack", int'(bus.ack), 0);
    chk("s2 e10 ce", int'(bus.ce), 1);
    chk("s2 e10 busy", int'(bus.busy), 1);
    hold(13, 1'b0, 1'b1);
    chk("s2 e13 ce", int'(bus.ce), 1);
    hold(14, 1'b0, 1'b1);
    chk("s2 e14 ce", int'(bus.ce), 0);
    chk("s2 e14 busy", int'(bus.busy), 0);

    // 3: stop held off by a busy downstream
    do_reset();
    hold(9, 1'b1, 1'b1);
    hold(19, 1'b0, 1'b0);
    chk("s3 e19 ce", int'(bus.ce), 1);
    chk("s3 e19 busy", int'(bus.busy), 1);
    hold(20, 1'b0, 1'b1);
    chk("s3 e20 ce", int'(bus.ce), 0);
    chk("s3 e20 busy", int'(bus.busy), 0);

    // 4: request returns during drain
    do_reset();
    hold(9, 1'b1, 1'b1);
    hold(11, 1'b0, 1'b1);
    chk("s4 e11 ack", int'(bus.ack), 0);
    chk("s4 e11 ce", int'(bus.ce), 1);
    hold(12, 1'b1, 1'b1);
    chk("s4 e12 ack", int'(bus.ack), 1);
    chk("s4 e12 ce", int'(bus.ce), 1);
    chk("s4 e12 busy", int'(bus.busy), 0);
    chk("s4 e12 on_cnt", int'(bus.on_cnt), 1);

    // 5: request aborted during settle
    do_reset();
    hold(3, 1'b1, 1'b1);
    hold(4, 1'b0, 1'b1);
    chk("s5 e4 ack", int'(bus.ack), 0);
    chk("s5 e4 ce", int'(bus.ce), 1);
    chk("s5 e4 busy", int'(bus.busy), 1);
    hold(7, 1'b0, 1'b1);
    chk("s5 e7 ce", int'(bus.ce), 1);
    hold(8, 1'b0, 1'b1);
    chk("s5 e8 ce", int'(bus.ce), 0);
    chk("s5 e8 ack", int'(bus.ack), 0);
    chk("s5 e8 on_cnt", int'(bus.on_cnt), 0);

    // 6a: reset during settle
    do_reset();
    hold(4, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("s6 rst ce", int'(bus.ce), 0);
    chk("s6 rst ack", int'(bus.ack), 0);
    chk("s6 rst busy", int'(bus.busy), 0);
    chk("s6 rst on_cnt", int'(bus.on_cnt), 0);

    // 6b: 300 full on/off cycles, on_cnt saturates
    do_reset();
    for (int k = 0; k < 300; k++) begin
      repeat (SETTLE + 1) step(1'b1, 1'b1, 1'b0);
      repeat (DRAIN + 1) step(1'b0, 1'b1, 1'b0);
      if (k == 0) chk("s6 cyc0 ce off", int'(bus.ce), 0);
      if (k == 253) chk("s6 on_cnt 254", int'(bus.on_cnt), 254);
      if (k == 254) chk("s6 on_cnt 255", int'(bus.on_cnt), 255);
    end
    chk("s6 on_cnt sat", int'(bus.on_cnt), 255);
    chk("s6 end ce", int'(bus.ce), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
